// File: rtl/apb_master_q.sv
// Queued APB4 requester: commands are buffered in a FIFO and each one runs as a SETUP->ACCESS
// transfer; the result goes into a single response slot with status OKAY, SLVERR or TIMEOUT.
//
// state  | meaning
// IDLE   | bus idle; launch the FIFO head when the response slot is free or being drained
// SETUP  | psel high, penable low; timeout counter cleared
// ACCESS | psel and penable high; wait for pready or the timeout limit
module apb_master_q #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int CMD_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                pclk,
   input  logic                preset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_status,
   output logic                rsp_write,
   output logic                psel,
   output logic                penable,
   output logic [ADDR_W-1:0]   paddr,
   output logic                pwrite,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pready,
   input  logic                pslverr,
   output logic                busy
);
   localparam int STRB_W = DATA_W / 8;
   localparam int PTR_W  = $clog2(CMD_DEPTH);
   localparam int CTR_W  = PTR_W + 1;
   localparam int ENT_W  = 1 + ADDR_W + DATA_W + STRB_W;
   localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [CTR_W-1:0] FULL_CNT = CTR_W'(CMD_DEPTH);
   localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(TIMEOUT_CYC);
   localparam logic [1:0] ST_OKAY    = 2'b00;
   localparam logic [1:0] ST_SLVERR  = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t            state, state_nxt;
   logic [ENT_W-1:0]  mem [CMD_DEPTH];
   logic [ENT_W-1:0]  head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CTR_W-1:0]  count;
   logic              full, empty, push, pop, done, timed_out;
   logic [CNT_W-1:0]  cnt, cnt_inc;
   logic              xfer_write;
   logic [ADDR_W-1:0] xfer_addr;
   logic [DATA_W-1:0] xfer_wdata;
   logic [STRB_W-1:0] xfer_strb;

   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign head      = mem[rd_ptr];
   assign cnt_inc   = cnt + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      done      = 1'b0;
      timed_out = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && (!rsp_valid || rsp_ready)) begin
               pop       = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: state_nxt = ACCESS;
         ACCESS: begin
            if (pready) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (TIMEOUT_CYC != 0 && cnt_inc == TO_LIM) begin
               timed_out = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Storage has no reset: the pointers define which entries are live.
   always_ff @(posedge pclk) begin
      if (push) mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_strb};
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         cnt        <= '0;
         xfer_write <= 1'b0;
         xfer_addr  <= '0;
         xfer_wdata <= '0;
         xfer_strb  <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_status <= ST_OKAY;
         rsp_write  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      count <= count + CTR_W'(1);
         else if (pop && !push) count <= count - CTR_W'(1);

         if (pop) begin
            xfer_write <= head[ENT_W-1];
            xfer_addr  <= head[ENT_W-2 -: ADDR_W];
            xfer_wdata <= head[ENT_W-1] ? head[STRB_W +: DATA_W] : '0;
            xfer_strb  <= head[ENT_W-1] ? head[STRB_W-1:0] : '0;
         end

         // Saturating so a disabled timeout can never wrap back to zero.
         if (state == SETUP)                                cnt <= '0;
         else if (state == ACCESS && !pready && cnt != '1) cnt <= cnt_inc;

         if (done) begin
            rsp_valid  <= 1'b1;
            rsp_rdata  <= (!xfer_write && !pslverr) ? prdata : '0;
            rsp_status <= pslverr ? ST_SLVERR : ST_OKAY;
            rsp_write  <= xfer_write;
         end else if (timed_out) begin
            rsp_valid  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_status <= ST_TIMEOUT;
            rsp_write  <= xfer_write;
         end else if (rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
         end
      end
   end

   assign psel    = (state != IDLE);
   assign penable = (state == ACCESS);
   assign paddr   = psel ? xfer_addr  : '0;
   assign pwrite  = psel ? xfer_write : 1'b0;
   assign pwdata  = psel ? xfer_wdata : '0;
   assign pstrb   = psel ? xfer_strb  : '0;
   assign busy    = psel || !empty;
endmodule

// File: tb/tb_apb_master_q.sv
// Bench for apb_master_q: a transaction-level model (command queue, one in-flight transfer,
// one response slot) is compared against the DUT every cycle; directed cases pin literal values.
module tb_apb_master_q;
   localparam int DEPTH = 4;
   localparam int TO    = 16;

   logic        pclk = 1'b0;
   logic        preset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_status;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0]  pstrb;
   logic        pready, pslverr, busy;

   apb_master_q #(.ADDR_W(32), .DATA_W(32), .CMD_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_status(rsp_status), .rsp_write(rsp_write),
      .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
      .pslverr(pslverr), .busy(busy)
   );

   initial forever #5 pclk = ~pclk;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
   } cmd_t;

   typedef struct packed {
      logic        wr;
      logic [1:0]  st;
      logic [31:0] rd;
   } rsp_t;

   cmd_t        mq[$];
   cmd_t        cur;
   bit          inx;
   int          acc_n;
   bit          slot_v;
   logic [31:0] slot_rdata;
   logic [1:0]  slot_status;
   logic        slot_write;
   rsp_t        got_q[$];
   int          n_push;
   int          checks = 0;
   int          errors = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Advance the transaction model by one clock edge using the inputs presented at that edge.
   task automatic model_step();
      bit   launch, do_push;
      cmd_t c;
      if (preset) begin
         mq.delete();
         inx = 0; acc_n = 0; slot_v = 0;
         slot_rdata = 32'h0; slot_status = 2'd0; slot_write = 1'b0;
         return;
      end
      do_push = cmd_valid && (mq.size() < DEPTH);
      launch  = !inx && (mq.size() > 0) && (!slot_v || rsp_ready);
      if (slot_v && rsp_ready) slot_v = 0;
      if (inx) begin
         if (acc_n == 0) acc_n = 1;
         else if (pready) begin
            inx = 0; slot_v = 1; slot_write = cur.wr;
            slot_status = pslverr ? 2'd1 : 2'd0;
            slot_rdata  = (!cur.wr && !pslverr) ? prdata : 32'h0;
         end else if (TO != 0 && acc_n == TO) begin
            inx = 0; slot_v = 1; slot_write = cur.wr;
            slot_status = 2'd2; slot_rdata = 32'h0;
         end else acc_n++;
      end
      if (launch) begin
         cur = mq.pop_front();
         inx = 1; acc_n = 0;
      end
      if (do_push) begin
         c.wr = cmd_write; c.addr = cmd_addr; c.wdata = cmd_wdata; c.strb = cmd_strb;
         mq.push_back(c);
      end
   endtask

   task automatic compare();
      chk("psel",      32'(psel),      32'(inx));
      chk("penable",   32'(penable),   32'(inx && acc_n > 0));
      chk("paddr",     paddr,          inx ? cur.addr : 32'h0);
      chk("pwrite",    32'(pwrite),    32'(inx && cur.wr));
      chk("pwdata",    pwdata,         (inx && cur.wr) ? cur.wdata : 32'h0);
      chk("pstrb",     32'(pstrb),     (inx && cur.wr) ? 32'(cur.strb) : 32'h0);
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      chk("busy",      32'(busy),      32'(inx || mq.size() > 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(slot_v));
      if (slot_v) begin
         chk("rsp_rdata",  rsp_rdata,       slot_rdata);
         chk("rsp_status", 32'(rsp_status), 32'(slot_status));
         chk("rsp_write",  32'(rsp_write),  32'(slot_write));
      end
   endtask

   task automatic cycle();
      rsp_t r;
      if (rsp_valid && rsp_ready) begin
         r.wr = rsp_write; r.st = rsp_status; r.rd = rsp_rdata;
         got_q.push_back(r);
      end
      if (cmd_valid && cmd_ready) n_push++;
      @(posedge pclk);
      model_step();
      @(negedge pclk);
      compare();
   endtask

   task automatic set_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   p_rdy;
      logic exp_wr [5];
      exp_wr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      preset = 1'b1; cmd_valid = 1'b0; set_cmd(1'b0, 32'h0, 32'h0, 4'h0);
      rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
      n_push = 0;
      @(negedge pclk);
      cycle(); cycle();
      preset = 1'b0;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_psel",      32'(psel),      32'd0);
      chk("rst_paddr",     paddr,          32'h0);

      // single write, pready high
      rsp_ready = 1'b1; pready = 1'b1;
      set_cmd(1'b1, 32'h0000_A004, 32'hDEAD_BEEF, 4'hF); cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      chk("wr_psel_after_push", 32'(psel), 32'd0);
      cycle();
      chk("wr_setup_psel",    32'(psel),    32'd1);
      chk("wr_setup_penable", 32'(penable), 32'd0);
      chk("wr_setup_paddr",   paddr,        32'h0000_A004);
      chk("wr_setup_pwdata",  pwdata,       32'hDEAD_BEEF);
      cycle();
      chk("wr_access_penable", 32'(penable), 32'd1);
      chk("wr_access_paddr",   paddr,        32'h0000_A004);
      chk("wr_access_pwdata",  pwdata,       32'hDEAD_BEEF);
      cycle();
      chk("wr_rsp_valid",  32'(rsp_valid),  32'd1);
      chk("wr_rsp_status", 32'(rsp_status), 32'd0);
      chk("wr_rsp_write",  32'(rsp_write),  32'd1);
      chk("wr_psel_idle",  32'(psel),       32'd0);
      cycle();

      // read, pready delayed three ACCESS cycles
      pready = 1'b0; prdata = 32'h1234_5678;
      set_cmd(1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF); cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (penable) n++;
         if (n == 4) pready = 1'b1;
         if (!psel && n > 0) break;
      end
      chk("rd_penable_cycles", n, 32'd4);
      chk("rd_rsp_valid",  32'(rsp_valid),  32'd1);
      chk("rd_rsp_rdata",  rsp_rdata,       32'h1234_5678);
      chk("rd_rsp_status", 32'(rsp_status), 32'd0);
      cycle();

      // read with slave error
      pready = 1'b1; pslverr = 1'b1;
      set_cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0); cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      cycle(); cycle(); cycle();
      chk("err_rsp_valid",  32'(rsp_valid),  32'd1);
      chk("err_rsp_status", 32'(rsp_status), 32'd1);
      chk("err_rsp_rdata",  rsp_rdata,       32'h0);
      pslverr = 1'b0;
      cycle();

      // timeout, then a late pready pulse
      pready = 1'b0; rsp_ready = 1'b0;
      set_cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0); cmd_valid = 1'b1;
      cycle();
      cmd_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (penable) n++;
         if (!psel && n > 0) break;
      end
      chk("to_access_cycles", n, 32'd16);
      chk("to_rsp_status", 32'(rsp_status), 32'd2);
      chk("to_rsp_rdata",  rsp_rdata,       32'h0);
      pready = 1'b1;
      cycle();
      pready = 1'b0;
      cycle();
      chk("to_late_status", 32'(rsp_status), 32'd2);
      chk("to_late_valid",  32'(rsp_valid),  32'd1);
      chk("to_late_psel",   32'(psel),       32'd0);
      rsp_ready = 1'b1;
      cycle();

      // five commands into a four-deep FIFO with the response path stalled
      rsp_ready = 1'b0; pready = 1'b1; prdata = 32'hCAFE_0001;
      got_q.delete(); n_push = 0;
      for (int i = 0; i < 40 && n_push < 5; i++) begin
         set_cmd(exp_wr[n_push], 32'h100 + 32'(4 * n_push), $urandom, 4'($urandom));
         cmd_valid = 1'b1;
         cycle();
      end
      cmd_valid = 1'b0;
      cycle(); cycle(); cycle();
      chk("fill_pushed",    n_push,         32'd5);
      chk("fill_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("fill_psel",      32'(psel),      32'd0);
      chk("fill_rsp_valid", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      for (int i = 0; i < 60 && got_q.size() < 5; i++) cycle();
      chk("fill_rsp_count", got_q.size(), 32'd5);
      for (int i = 0; i < got_q.size() && i < 5; i++) begin
         chk("fill_rsp_order_write", 32'(got_q[i].wr), 32'(exp_wr[i]));
         chk("fill_rsp_rdata", got_q[i].rd, exp_wr[i] ? 32'h0 : 32'hCAFE_0001);
      end

      // reset while in ACCESS with a second command queued
      pready = 1'b0;
      set_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0); cmd_valid = 1'b1;
      cycle();
      set_cmd(1'b1, 32'h0000_0044, 32'h5555_AAAA, 4'h3);
      cycle();
      cmd_valid = 1'b0;
      cycle();
      chk("rstm_in_access", 32'(penable), 32'd1);
      preset = 1'b1;
      cycle();
      preset = 1'b0;
      chk("rstm_psel",      32'(psel),      32'd0);
      chk("rstm_penable",   32'(penable),   32'd0);
      chk("rstm_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstm_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rstm_busy",      32'(busy),      32'd0);

      // randomized traffic, including a low-pready segment that forces timeouts
      for (int seg = 0; seg < 8; seg++) begin
         p_rdy = (seg == 3) ? 3 : 45 + 7 * seg;
         for (int c = 0; c < 300; c++) begin
            cmd_valid = ($urandom_range(0, 99) < 40);
            set_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
            pready    = ($urandom_range(0, 99) < p_rdy);
            pslverr   = ($urandom_range(0, 9) == 0);
            prdata    = $urandom;
            rsp_ready = ($urandom_range(0, 99) < 60);
            preset    = ($urandom_range(0, 499) == 0);
            cycle();
         end
      end
      preset = 1'b0; cmd_valid = 1'b0;
      cycle(); cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_master_q.md
Name: apb_master_q

Overview:
- Parametrised, queued APB4 requester; next generation of the team's single-shot APB master.
- Accepts read/write commands over a valid/ready command port into an internal FIFO.
- Executes each command as a standard SETUP→ACCESS APB transfer with PSTRB.
- Returns read data plus a completion status (OKAY, SLVERR, TIMEOUT) over a valid/ready response port.
- Sits between a local controller and one APB slave segment; replaces the fixed-address, no-error, no-backpressure master.

Parameters:
- ADDR_W, 32, width of command address and paddr.
- DATA_W, 32, data width; legal values 8, 16, 32. STRB_W = DATA_W/8.
- CMD_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT_CYC, 16, maximum ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- preset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !fifo_full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- cmd_strb  in  STRB_W  write byte strobes; ignored for reads.
- rsp_valid  out  1  response slot occupied.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and timeouts.
- rsp_status  out  2  00 OKAY, 01 SLVERR, 10 TIMEOUT.
- rsp_write  out  1  echo of the completed command type.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_W  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_W  APB write data.
- pstrb  out  STRB_W  APB strobes.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error; sampled only with pready in ACCESS.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (preset high at a pclk edge):
  - FSM→IDLE; FIFO emptied.
  - All outputs 0, except cmd_ready = 1.
  - Reset mid-transfer aborts at once: psel/penable low the next cycle, no response is generated, and a pending response is discarded.
- Command push: on cmd_valid && cmd_ready. A push and a pop in the same cycle are both allowed when the FIFO is full; cmd_ready stays low in that cycle (no bypass). Pointers wrap modulo CMD_DEPTH.
- FSM IDLE:
  - Go to SETUP when the FIFO is non-empty and (!rsp_valid || rsp_ready).
  - On that edge, pop the head into the transfer register and drive it onto paddr, pwrite, pwdata, pstrb.
  - For reads, pwdata = 0 and pstrb = 0.
  - The cycle after a pop, the APB bus reflects the popped command.
- FSM SETUP: psel = 1, penable = 0; unconditionally go to ACCESS next cycle. The timeout counter is cleared.
- FSM ACCESS:
  - psel = 1, penable = 1.
  - paddr, pwrite, pwdata and pstrb stay stable throughout SETUP and ACCESS.
  - Each cycle with pready = 0, the counter increments.
  - On pready = 1: load the response slot with rdata = prdata if read and !pslverr, else 0; status = pslverr ? 01 : 00; rsp_write = pwrite. Then go to IDLE.
  - If TIMEOUT_CYC ≠ 0 and the counter reaches TIMEOUT_CYC with pready still 0: load the response with status 10 and rdata 0, then go to IDLE.
  - A late pready arriving after a timeout is ignored.
- Transfer timing:
  - After ACCESS completion, psel and penable are low for at least one IDLE cycle. No back-to-back SETUP.
  - Minimum command-to-command spacing is 3 cycles with pready tied high.
- Outputs in IDLE: psel = 0, penable = 0; paddr, pwrite, pwdata and pstrb are driven to 0.
- Response slot: rsp_valid rises the cycle after completion and holds its fields stable until rsp_ready. A launch in IDLE is blocked while the slot is full and not being drained.
- Counter width: clog2(TIMEOUT_CYC+1); it must not wrap.

Test Plan:
- Reset then single write (addr 0x0000_A004, wdata 0xDEAD_BEEF, strb 0xF, pready = 1):
  - psel rises 1 cycle after push, penable the cycle after, with paddr and pwdata stable across both.
  - Response is status 00, rsp_write = 1.
- Read with pready delayed 3 ACCESS cycles, prdata = 0x1234_5678: penable is held 4 cycles; response has rdata 0x1234_5678, status 00.
- Read with pslverr = 1 at pready: status 01, rdata 0.
- TIMEOUT_CYC = 16, pready tied 0:
  - Exactly 16 ACCESS cycles, then psel drops.
  - Status 10; a later pready pulse has no effect.
- Push 5 commands into CMD_DEPTH = 4 with rsp_ready = 0:
  - cmd_ready drops after 4; only the first transfer executes until rsp_ready goes high.
  - All 5 responses are then returned in order.
- Assert preset while in ACCESS: the next cycle has psel = 0, penable = 0, rsp_valid = 0, cmd_ready = 1, busy = 0.
